uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Downstream consumer of the UART receive stage: takes one-cycle byte strobes from the receiver, buffers them in a ring buffer and re-serialises them as 8N1 UART frames on the board TX pin at the same bit rate. It decouples receive timing from transmit timing, so bursts of received bytes echo back without loss up to the buffer depth. Sits between the receive block's byte output and the uart_txd pin.

Parameters:
CLOCKS_PER_BIT, 5624, clocks per UART bit (clk / 9600 bps); every transmitted bit lasts exactly this many clocks.
DEPTH_LOG2, 4, log2 of ring-buffer depth (default 16 entries).

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
wr_en  input  1  one-cycle strobe: wr_data holds a received byte.
wr_data  input  8  byte to enqueue.
full  output  1  buffer holds 2^DEPTH_LOG2 entries (registered).
empty  output  1  buffer holds 0 entries (registered).
count  output  DEPTH_LOG2+1  current occupancy.
overflow  output  1  sticky: a write was dropped because the buffer was full.
tx_busy  output  1  a frame is on the line (START/DATA/STOP).
tx_out  output  1  serial line, idle high.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset values: tx_out=1, tx_busy=0, empty=1, full=0, count=0, overflow=0; read/write pointers=0; FSM=IDLE; bit and clock counters=0.
- Reset mid-frame: frame aborted, tx_out=1 from the next cycle, buffer contents discarded.
- Write: accepted when wr_en=1 and full=0 (registered value at that edge); stored at wr_ptr, wr_ptr+1 modulo 2^DEPTH_LOG2.
- Write while full: byte dropped, overflow set to 1. A pop in the same cycle does not rescue it. overflow clears only on reset.
- Pop: FSM in IDLE with empty=0 reads the head byte into the shift register, rd_ptr+1 (wraps modulo depth), next state START.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- count/full/empty update on the edge after the write/pop.
- FSM states:
  - IDLE: tx_out=1.
  - START: tx_out=0 for CLOCKS_PER_BIT clocks.
  - DATA: 8 bits, LSB first, each CLOCKS_PER_BIT clocks; a 3-bit index runs 0..7.
  - STOP: tx_out=1 for CLOCKS_PER_BIT clocks, then IDLE.
- Frame: exactly 10*CLOCKS_PER_BIT clocks.
- Gap rules: IDLE lasts at least one clock between frames, so back-to-back frames are separated by exactly 1 clock of idle-high.
- Latency: wr_en at edge N with buffer empty and FSM IDLE gives count=1 after N, pop at N+1, tx_out falls at N+2.
- Bit counter width: 20 bits, sufficient for the default CLOCKS_PER_BIT. Counter compares against CLOCKS_PER_BIT-1 and reloads 0.
- tx_out is driven from a register (glitch-free).

Test Plan:
1. CLOCKS_PER_BIT=4; single write 0xA5 -> tx_out low 2 cycles after strobe; line sequence 0,1,0,1,0,0,1,0,1,1, each level 4 clocks; empty=1 and tx_busy=0 afterwards.
2. Three consecutive-cycle writes 0x01, 0x80, 0xFF -> three frames in order; exactly 1 idle-high clock between frames; count peaks at 2.
3. 18 writes on consecutive cycles from empty -> first 17 accepted (one popped at cycle N+1); full=1 after the 17th; 18th dropped; overflow=1 stays set; the 17 bytes are transmitted in order.
4. Write during the pop cycle with count=1 -> count remains 1, both pointers advance, no overflow.
5. Assert reset mid-DATA of a frame with 3 bytes queued -> next cycle tx_out=1, count=0, empty=1, overflow=0; a new write then transmits normally.
6. 40 bytes written in paced bursts never exceeding depth -> all 40 transmitted in order across pointer wrap; overflow=0 throughout.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Ring-buffered 8N1 UART transmitter: queues bytes strobed in by the receive stage
// and re-serialises them LSB first on tx_out at CLOCKS_PER_BIT clocks per bit.
module uart_tx_fifo #(
    parameter int CLOCKS_PER_BIT = 5624,
    parameter int DEPTH_LOG2     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  tx_busy,
    output logic                  tx_out
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [19:0]         BIT_LAST  = 20'(CLOCKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e                  state_q,    state_d;
    logic [19:0]             clk_cnt_q,  clk_cnt_d;
    logic [2:0]              bit_idx_q,  bit_idx_d;
    logic [7:0]              shift_q,    shift_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q,    count_d;
    logic                    full_q,     full_d;
    logic                    empty_q,    empty_d;
    logic                    overflow_q, overflow_d;
    logic                    tx_busy_q,  tx_busy_d;
    logic                    tx_out_q,   tx_out_d;
    logic [7:0]              mem_q [DEPTH];

    logic push;
    logic pop;
    logic bit_end;

    assign push    = wr_en && !full_q;
    assign pop     = (state_q == IDLE) && !empty_q;
    assign bit_end = (clk_cnt_q == BIT_LAST);

    // NOTE: the byte storage has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (wr_en && full_q);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);

        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d   = mem_q[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    clk_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line levels follow the state one clock later, so a pop edge is followed by the start bit.
        case (state_q)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_q[0];
            default: tx_out_d = 1'b1;
        endcase
        tx_busy_d = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_out_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_busy_q  <= tx_busy_d;
            tx_out_q   <= tx_out_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_busy  = tx_busy_q;
    assign tx_out   = tx_out_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-and-timeline model predicts every output each cycle.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;
    localparam int NEVER = 1000000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, tx_busy, tx_out;
    logic [DL:0] count;

    int total = 0;
    int bad   = 0;

    // Model: bytes waiting, cycles until the transmitter is free, age of the frame on the line.
    logic [7:0] q [$];
    int         busy = 0;
    int         age = NEVER;
    logic [9:0] frame = 10'h3FF;
    bit         m_over = 1'b0;

    uart_tx_fifo #(
        .CLOCKS_PER_BIT(CPB),
        .DEPTH_LOG2    (DL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow),
        .tx_busy (tx_busy),
        .tx_out  (tx_out)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model advances on the same edge from its pre-edge state.
    task automatic tick(input bit rst, input bit we, input logic [7:0] d);
        bit         full_pre;
        bit         popm;
        logic [7:0] b;
        reset   = rst;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        if (rst) begin
            q.delete();
            busy   = 0;
            age    = NEVER;
            m_over = 1'b0;
        end else begin
            full_pre = (q.size() == DEPTH);
            popm     = (busy == 0) && (q.size() != 0);
            if (busy > 0) busy--;
            if (age < NEVER) age++;
            if (popm) begin
                b     = q.pop_front();
                frame = {1'b1, b, 1'b0};
                age   = 0;
                busy  = FRAME;
            end
            if (we) begin
                if (full_pre) m_over = 1'b1;
                else q.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [9:0] exp_vec();
        bit   on;
        logic e_tx;
        on   = (age >= 1) && (age <= FRAME);
        e_tx = on ? frame[(age - 1) / CPB] : 1'b1;
        return {e_tx, on, 5'(q.size()), q.size() == DEPTH, q.size() == 0, m_over};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {tx_out, tx_busy, count, full, empty, overflow};
    endfunction

    function automatic bit model_active();
        return (q.size() != 0) || (busy != 0) || (age <= FRAME);
    endfunction

    task automatic test_reset();
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        total++;
        if (obs_vec() !== 10'b1000000_010) begin
            bad++;
            $display("FAIL reset_values got=%b expected=%b", obs_vec(), 10'b1000000_010);
        end
        tick(1'b0, 1'b0, 8'h00);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_release got=%b expected=%b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        logic [9:0] seq;
        logic [9:0] want_seq;
        int         fall;
        fall     = -1;
        seq      = '0;
        want_seq = 10'b11_0100_1010;
        tick(1'b0, 1'b1, 8'hA5);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL single_write got=%b expected=%b", obs_vec(), exp_vec());
        end
        for (int i = 1; i <= FRAME + 4; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL single_line cyc=%0d got=%b expected=%b", i, obs_vec(), exp_vec());
            end
            if (tx_out === 1'b0 && fall < 0) fall = i;
            if (i >= 2 && i < 2 + FRAME && (i - 2) % CPB == 0) seq[(i - 2) / CPB] = tx_out;
        end
        total++;
        if (fall != 2) begin
            bad++;
            $display("FAIL single_latency got=%0d expected=2", fall);
        end
        total++;
        if (seq !== want_seq) begin
            bad++;
            $display("FAIL single_sequence got=%b expected=%b", seq, want_seq);
        end
        total++;
        if ({empty, tx_busy} !== 2'b10) begin
            bad++;
            $display("FAIL single_after got empty/busy=%b expected=10", {empty, tx_busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int         starts [$];
        int         maxc;
        logic       prev_busy;
        bytes     = '{8'h01, 8'h80, 8'hFF};
        maxc      = 0;
        prev_busy = tx_busy;
        for (int c = 0; c < 3 + 3 * (FRAME + 1) + 6; c++) begin
            if (c < 3) tick(1'b0, 1'b1, bytes[c]);
            else tick(1'b0, 1'b0, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL b2b_line cyc=%0d got=%b expected=%b", c, obs_vec(), exp_vec());
            end
            if (int'(count) > maxc) maxc = int'(count);
            if (tx_busy === 1'b1 && prev_busy === 1'b0) starts.push_back(c);
            prev_busy = tx_busy;
        end
        total++;
        if (maxc != 2) begin
            bad++;
            $display("FAIL b2b_peak_count got=%0d expected=2", maxc);
        end
        total++;
        if (starts.size() != 3) begin
            bad++;
            $display("FAIL b2b_frames got=%0d expected=3", starts.size());
        end else if (starts[1] - starts[0] != FRAME + 1 || starts[2] - starts[1] != FRAME + 1) begin
            bad++;
            $display("FAIL b2b_spacing got=%0d,%0d expected=%0d", starts[1] - starts[0],
                     starts[2] - starts[1], FRAME + 1);
        end
    endtask

    task automatic test_overflow();
        tick(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 18; k++) begin
            tick(1'b0, 1'b1, 8'($urandom));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL ovf_write k=%0d got=%b expected=%b", k, obs_vec(), exp_vec());
            end
            if (k == 16) begin
                total++;
                if (full !== 1'b1 || overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_full_after_17 got full/ovf=%b expected=10", {full, overflow});
                end
            end
        end
        total++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            bad++;
            $display("FAIL ovf_drop got ovf=%b count=%0d expected ovf=1 count=16", overflow, count);
        end
        for (int i = 0; i < 20000 && model_active(); i++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL ovf_drain cyc=%0d got=%b expected=%b", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (overflow !== 1'b1 || empty !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky got ovf/empty=%b expected=11", {overflow, empty});
        end
    endtask

    task automatic test_pop_collide();
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h3A);
        tick(1'b0, 1'b1, 8'hC5);
        total++;
        if (count !== 5'd1 || overflow !== 1'b0 || empty !== 1'b0) begin
            bad++;
            $display("FAIL collide_count got count=%0d ovf=%b empty=%b expected 1,0,0", count, overflow, empty);
        end
        for (int i = 0; i < 20000 && model_active(); i++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL collide_drain cyc=%0d got=%b expected=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 8'h50 + 8'(k));
        for (int i = 0; i < 100 && age < 3 * CPB; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL midrst_pre cyc=%0d got=%b expected=%b", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (count !== 5'd3 || tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_setup got count=%0d busy=%b expected 3,1", count, tx_busy);
        end
        tick(1'b1, 1'b0, 8'h00);
        total++;
        if ({tx_out, tx_busy, count, empty, overflow} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL midrst_abort got=%b expected=%b", {tx_out, tx_busy, count, empty, overflow},
                     {1'b1, 1'b0, 5'd0, 1'b1, 1'b0});
        end
        tick(1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < 20000 && model_active(); i++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL midrst_after cyc=%0d got=%b expected=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_wrap();
        int   sent;
        int   frames;
        int   room;
        int   b;
        logic prev_busy;
        sent   = 0;
        frames = 0;
        tick(1'b1, 1'b0, 8'h00);
        prev_busy = tx_busy;
        for (int it = 0; it < 1000 && sent < 40; it++) begin
            room = DEPTH - 1 - q.size();
            b    = (room < 6) ? room : 6;
            if (40 - sent < b) b = 40 - sent;
            if (b > 0) b = $urandom_range(1, b);
            for (int k = 0; k < b + $urandom_range(5, 60); k++) begin
                if (k < b) tick(1'b0, 1'b1, 8'($urandom));
                else tick(1'b0, 1'b0, 8'h00);
                total++;
                if (obs_vec() !== exp_vec()) begin
                    bad++;
                    $display("FAIL wrap_line sent=%0d got=%b expected=%b", sent, obs_vec(), exp_vec());
                end
                if (tx_busy === 1'b1 && prev_busy === 1'b0) frames++;
                prev_busy = tx_busy;
            end
            sent += b;
        end
        for (int i = 0; i < 20000 && model_active(); i++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL wrap_drain cyc=%0d got=%b expected=%b", i, obs_vec(), exp_vec());
            end
            if (tx_busy === 1'b1 && prev_busy === 1'b0) frames++;
            prev_busy = tx_busy;
        end
        total++;
        if (frames != 40 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL wrap_total got frames=%0d ovf=%b expected 40,0", frames, overflow);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_pop_collide();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
